// File: rtl/terminate_pipeline_buf.sv
// Branch-target resolve stage feeding a 2-entry skid FIFO toward the terminate/commit stage.
// Optional feature: define TERMINATE_MISPREDICT_EN to keep a per-entry (target != predicted_addr) flag.
module terminate_pipeline_buf #(
    parameter int ADDR_W = 16,
    parameter int ROB_W  = 5,
    parameter int ARCH_W = 8,
    parameter int PHYS_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] reg_base_val,
    input  logic [7:0]        flag_vals,
    input  logic [7:0]        offset,
    input  logic [3:0]        immediate,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ROB_W-1:0]  ROB_entries,
    input  logic [ARCH_W-1:0] arch_dest_regs,
    input  logic [PHYS_W-1:0] phys_dest_regs,
    input  logic              flush,
    input  logic [ADDR_W-1:0] predicted_addr,
    output logic [ADDR_W-1:0] result_addr,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              mispredict,
    output logic [ROB_W-1:0]  ROB_entries_out,
    output logic [ARCH_W-1:0] arch_dest_regs_out,
    output logic [PHYS_W-1:0] phys_dest_regs_out
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ROB_W-1:0]  rob;
        logic [ARCH_W-1:0] arch;
        logic [PHYS_W-1:0] phys;
`ifdef TERMINATE_MISPREDICT_EN
        logic              mis;
`endif
    } entry_t;

    occ_e   occ_q, occ_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_entry;

    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              push;
    logic              pop;

    always_comb begin
        taken = opcode[0] | (flag_vals[immediate[2:0]] == ~immediate[3]);
        if (opcode[0]) begin
            target = reg_base_val + ADDR_W'(immediate);
        end else if (taken) begin
            target = reg_base_val + ADDR_W'(signed'(offset)) + ADDR_W'(1);
        end else begin
            target = reg_base_val + ADDR_W'(1);
        end
    end

    always_comb begin
        new_entry      = '0;
        new_entry.addr = target;
        new_entry.rob  = ROB_entries;
        new_entry.arch = arch_dest_regs;
        new_entry.phys = phys_dest_regs;
`ifdef TERMINATE_MISPREDICT_EN
        new_entry.mis  = (target != predicted_addr);
`endif
    end

`ifndef TERMINATE_MISPREDICT_EN
    logic unused_predicted_addr;
    assign unused_predicted_addr = ^predicted_addr;
`endif

    // Handshakes depend only on registered occupancy, so instr_ready never sees result_ready.
    assign instr_ready  = (occ_q != FULL);
    assign result_valid = (occ_q != EMPTY);
    assign push         = instr_valid & instr_ready & ~flush;
    assign pop          = result_valid & result_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            occ_d = EMPTY;
        end else begin
            unique case (occ_q)
                EMPTY: begin
                    if (push) begin
                        head_d = new_entry;
                        occ_d  = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d = new_entry;
                        occ_d  = FULL;
                    end else if (pop) begin
                        occ_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d = tail_q;
                        occ_d  = ONE;
                    end
                end
                default: occ_d = EMPTY;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign result_addr        = head_q.addr;
    assign ROB_entries_out    = head_q.rob;
    assign arch_dest_regs_out = result_valid ? head_q.arch : '0;
    assign phys_dest_regs_out = result_valid ? head_q.phys : '0;
`ifdef TERMINATE_MISPREDICT_EN
    assign mispredict         = result_valid & head_q.mis;
`else
    assign mispredict         = 1'b0;
`endif

endmodule

// File: tb/tb_terminate_pipeline_buf.sv
// Self-checking bench for terminate_pipeline_buf: directed scenarios then random traffic,
// compared against a queue-based reference model built from the branch-target rules.
module tb_terminate_pipeline_buf;

    localparam int ADDR_W = 16;
    localparam int ROB_W  = 5;
    localparam int ARCH_W = 8;
    localparam int PHYS_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] reg_base_val;
    logic [7:0]        flag_vals;
    logic [7:0]        offset;
    logic [3:0]        immediate;
    logic              instr_valid;
    logic              instr_ready;
    logic [ROB_W-1:0]  ROB_entries;
    logic [ARCH_W-1:0] arch_dest_regs;
    logic [PHYS_W-1:0] phys_dest_regs;
    logic              flush;
    logic [ADDR_W-1:0] predicted_addr;
    logic [ADDR_W-1:0] result_addr;
    logic              result_valid;
    logic              result_ready;
    logic              mispredict;
    logic [ROB_W-1:0]  ROB_entries_out;
    logic [ARCH_W-1:0] arch_dest_regs_out;
    logic [PHYS_W-1:0] phys_dest_regs_out;

    always #5 clk = ~clk;

    terminate_pipeline_buf #(
        .ADDR_W(ADDR_W), .ROB_W(ROB_W), .ARCH_W(ARCH_W), .PHYS_W(PHYS_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .reg_base_val       (reg_base_val),
        .flag_vals          (flag_vals),
        .offset             (offset),
        .immediate          (immediate),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .ROB_entries        (ROB_entries),
        .arch_dest_regs     (arch_dest_regs),
        .phys_dest_regs     (phys_dest_regs),
        .flush              (flush),
        .predicted_addr     (predicted_addr),
        .result_addr        (result_addr),
        .result_valid       (result_valid),
        .result_ready       (result_ready),
        .mispredict         (mispredict),
        .ROB_entries_out    (ROB_entries_out),
        .arch_dest_regs_out (arch_dest_regs_out),
        .phys_dest_regs_out (phys_dest_regs_out)
    );

    typedef struct {
        int unsigned addr;
        int unsigned rob;
        int unsigned arch;
        int unsigned phys;
        bit          mis;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_target(int op, int base, int flags, int off, int imm);
        bit tk;
        int t;
        tk = ((op & 1) == 1) || (((flags >> (imm & 7)) & 1) == (((imm >> 3) & 1) == 1 ? 0 : 1));
        if ((op & 1) == 1)
            t = base + imm;
        else if (tk)
            t = base + ((off >= 128) ? off - 256 : off) + 1;
        else
            t = base + 1;
        return int'(t & ((1 << ADDR_W) - 1));
    endfunction

    task automatic drive(input int op, input int base, input int flags, input int off,
                         input int imm, input int pred);
        opcode         = 4'(op);
        reg_base_val   = ADDR_W'(base);
        flag_vals      = 8'(flags);
        offset         = 8'(off);
        immediate      = 4'(imm);
        predicted_addr = ADDR_W'(pred);
        ROB_entries    = ROB_W'($urandom);
        arch_dest_regs = ARCH_W'($urandom);
        phys_dest_regs = PHYS_W'($urandom);
    endtask

    task automatic drive_random();
        drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
    endtask

    // Compare outputs against the model, advance the model by one edge, then step the clock.
    task automatic cycle();
        exp_t e;
        bit   mv;
        bit   mr;
        mv = (q.size() > 0);
        mr = (q.size() < 2);
        check("instr_ready", instr_ready, mr);
        check("result_valid", result_valid, mv);
        if (mv) begin
            check("result_addr", result_addr, q[0].addr);
            check("rob_out", ROB_entries_out, q[0].rob);
            check("arch_out", arch_dest_regs_out, q[0].arch);
            check("phys_out", phys_dest_regs_out, q[0].phys);
            check("mispredict", mispredict, q[0].mis);
        end else begin
            check("arch_out_idle", arch_dest_regs_out, 0);
            check("phys_out_idle", phys_dest_regs_out, 0);
            check("mispredict_idle", mispredict, 0);
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            if (mv && result_ready) void'(q.pop_front());
            if (instr_valid && mr) begin
                e.addr = model_target(int'(opcode), int'(reg_base_val), int'(flag_vals),
                                      int'(offset), int'(immediate));
                e.rob  = ROB_entries;
                e.arch = arch_dest_regs;
                e.phys = phys_dest_regs;
`ifdef TERMINATE_MISPREDICT_EN
                e.mis  = (e.addr != predicted_addr);
`else
                e.mis  = 1'b0;
`endif
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; result_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state, held in reset for one more checked cycle.
        cycle();
        rst = 1'b0;

        // Unconditional jump.
        result_ready = 1'b1; instr_valid = 1'b1;
        drive(1, 'h1000, 0, 0, 'h5, 'h1005);
        cycle();
        check("uncond_valid", result_valid, 1);
        check("uncond_addr", result_addr, 'h1005);

        // Conditional backward branch, taken then not taken.
        drive(0, 'h2000, 'h00, 'hFE, 'hB, 0);
        cycle();
        check("cond_taken_addr", result_addr, 'h1FFF);
        drive(0, 'h2000, 'h08, 'hFE, 'hB, 0);
        cycle();
        check("cond_not_taken_addr", result_addr, 'h2001);
        instr_valid = 1'b0;
        cycle();

        // Backpressure: three offered, two held, then drained in order.
        result_ready = 1'b0; instr_valid = 1'b1;
        drive_random(); cycle();
        drive_random(); cycle();
        check("bp_ready_low", instr_ready, 0);
        drive_random(); cycle();
        instr_valid = 1'b0; result_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Flush with two entries held and a valid input offered.
        result_ready = 1'b0; instr_valid = 1'b1;
        drive_random(); cycle();
        drive_random(); cycle();
        flush = 1'b1; drive_random(); cycle();
        flush = 1'b0; instr_valid = 1'b0;
        check("flush_valid", result_valid, 0);
        check("flush_ready", instr_ready, 1);
        cycle();

        // Mispredict flag.
        result_ready = 1'b1; instr_valid = 1'b1;
        drive(1, 'h0100, 0, 0, 4, 'h0101);
        cycle();
`ifdef TERMINATE_MISPREDICT_EN
        check("mispredict_diff", mispredict, 1);
`else
        check("mispredict_diff", mispredict, 0);
`endif
        drive(1, 'h0100, 0, 0, 4, 'h0104);
        cycle();
        check("mispredict_same", mispredict, 0);

        // Wrap-around, then reset with one entry held.
        drive(0, 'hFFFF, 'h00, 'h10, 0, 0);
        cycle();
        check("wrap_addr", result_addr, 'h0000);
        instr_valid = 1'b0;
        cycle();
        result_ready = 1'b0; instr_valid = 1'b1;
        drive_random(); cycle();
        instr_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_valid", result_valid, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            instr_valid  = ($urandom_range(0, 3) != 0);
            result_ready = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 24) == 0);
            rst          = ($urandom_range(0, 59) == 0);
            drive_random();
            cycle();
        end
        rst = 1'b0; flush = 1'b0; instr_valid = 1'b0; result_ready = 1'b1;
        cycle(); cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/terminate_pipeline_buf.md
TERMINATE_PIPELINE_BUF -- requirements
Module: terminate_pipeline_buf

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, width of base value and result address.
REQ-002 SHALL provide parameter ROB_W, default 5, width of ROB entry tag.
REQ-003 SHALL provide parameter ARCH_W, default 8, width of packed architectural destination registers.
REQ-004 SHALL provide parameter PHYS_W, default 10, width of packed physical destination registers.
REQ-005 SHALL provide ports: clk input 1, the single clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL provide ports: opcode input 4; reg_base_val input ADDR_W; flag_vals input 8; offset input 8; immediate input 4.
REQ-007 SHALL provide ports: instr_valid input 1; instr_ready output 1; ROB_entries input ROB_W; arch_dest_regs input ARCH_W; phys_dest_regs input PHYS_W.
REQ-008 SHALL provide ports: flush input 1, which discards all buffered results; predicted_addr input ADDR_W, the front-end predicted next PC.
REQ-009 SHALL provide ports: result_addr output ADDR_W; result_valid output 1; result_ready input 1; mispredict output 1; ROB_entries_out output ROB_W; arch_dest_regs_out output ARCH_W; phys_dest_regs_out output PHYS_W.

Function
REQ-010 SHALL compute taken = opcode[0] OR (flag_vals[immediate[2:0]] == NOT immediate[3]).
REQ-011 SHALL compute target = reg_base_val + immediate (zero-extended to ADDR_W) if opcode[0]=1; reg_base_val + sext(offset) + 1 if opcode[0]=0 and taken; reg_base_val + 1 if not taken; all sums modulo 2^ADDR_W.
REQ-012 SHALL accept an instruction on the rising edge where instr_valid AND instr_ready AND NOT flush.
REQ-013 SHALL register accepted results into a 2-entry FIFO skid buffer (head, tail); latency from acceptance to result_valid is exactly 1 cycle.
REQ-014 SHALL drive instr_ready = 1 whenever the buffer holds fewer than 2 entries, from registered state only (no combinational path from result_ready).
REQ-015 SHALL drive result_valid = 1 whenever the buffer holds at least 1 entry; outputs present the head entry.
REQ-016 SHALL pop the head on an edge where result_valid AND result_ready.
REQ-017 SHALL allow simultaneous push and pop with 1 entry held: occupancy stays 1; new entry becomes head on the next cycle.
REQ-018 SHALL sustain one result per cycle while result_ready is held high.
REQ-019 SHALL hold head contents stable while result_valid=1 and result_ready=0.
REQ-020 SHALL drive arch_dest_regs_out and phys_dest_regs_out to 0 when result_valid=0; ROB_entries_out and result_addr are don't-care then.
REQ-021 SHALL, on flush=1, empty the buffer at that edge regardless of pop or push; the instruction offered in that cycle is dropped; result_valid=0 the following cycle.
REQ-022 SHALL preserve FIFO order; no entry is duplicated or lost absent flush or rst.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, empty the buffer; next cycle result_valid=0, mispredict=0, instr_ready=1, arch/phys outputs 0.
REQ-024 SHALL give rst priority over flush, push and pop; reset mid-transfer discards both entries.

Configuration
REQ-025 SHALL, with TERMINATE_MISPREDICT_EN defined, store per entry the flag (target != predicted_addr) captured at acceptance and drive it on mispredict while result_valid=1, else 0.
REQ-026 SHALL, without TERMINATE_MISPREDICT_EN, tie mispredict to 0, ignore predicted_addr, and store no comparison state; all other behaviour identical.

Verification
REQ-027 Unconditional: opcode=1, base=0x1000, imm=0x5, result_ready=1 -> next cycle result_valid=1, result_addr=0x1005.
REQ-028 Conditional backward taken: opcode=0, base=0x2000, offset=0xFE, flag_vals[3]=0, imm=0xB -> result_addr=0x1FFF; same with flag_vals[3]=1 -> 0x2001.
REQ-029 Backpressure: result_ready=0, push 3 back-to-back -> 2 accepted, instr_ready=0 in cycle 3; release ready -> results drain in order, one per cycle.
REQ-030 Flush with 2 entries held and a valid input -> next cycle result_valid=0, instr_ready=1, arch/phys outputs 0; dropped input never appears.
REQ-031 Mispredict (macro defined): base=0x0100, opcode=1, imm=4, predicted_addr=0x0101 -> mispredict=1; predicted_addr=0x0104 -> mispredict=0; macro undefined -> mispredict=0 both.
REQ-032 Wrap and reset: base=0xFFFF, not taken -> result_addr=0x0000; rst asserted with 1 entry held -> next cycle result_valid=0.
